// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared scratchpad constants and result-writer state encoding
package sp_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int MAX_DIM    = 4;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_WORDS  = MAX_DIM * MAX_DIM;
  localparam int FLAT_WIDTH = BUS_WIDTH * NUM_WORDS;
  localparam int BIT_IDX_W  = $clog2(FLAT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/sp_wr_addr_gen.sv
// rtl/sp_wr_addr_gen.sv - row-major row/col counter producing the scratchpad write address
module sp_wr_addr_gen
  import sp_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  adv_i,
  input  logic [1:0]            row_bound_i,
  input  logic [1:0]            col_bound_i,
  output logic                  last_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [1:0] row_q;
  logic [1:0] col_q;

  // Step through the matrix in row-major order, wrapping col at its bound.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      row_q <= 2'd0;
      col_q <= 2'd0;
    end else if (clr_i) begin
      row_q <= 2'd0;
      col_q <= 2'd0;
    end else if (adv_i) begin
      if (col_q == col_bound_i) begin
        col_q <= 2'd0;
        row_q <= row_q + 2'd1;
      end else begin
        col_q <= col_q + 2'd1;
      end
    end
  end

  // Flat address and final-element flag from the current position.
  always_comb begin
    addr_o = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(col_q);
    last_o = (row_q == row_bound_i) && (col_q == col_bound_i);
  end

endmodule

// File: rtl/sp_result_writer.sv
// rtl/sp_result_writer.sv - serializes a flat result matrix into a scratchpad slot (option: SP_WR_CLEAR_PAD_EN)
module sp_result_writer
  import sp_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [1:0]            n_dim_i,
  input  logic [1:0]            m_dim_i,
  input  logic [1:0]            target_sel_i,
  input  logic [FLAT_WIDTH-1:0] mat_flat_i,
  input  logic                  hold_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [BUS_WIDTH-1:0]  din_o,
  output logic                  ien_o,
  output logic [1:0]            element_write_sel_o,
  output logic                  busy_o,
  output logic                  done_o
);

  wr_state_e             state_q;
  wr_state_e             state_d;
  logic [FLAT_WIDTH-1:0] mat_q;
  logic [1:0]            n_q;
  logic [1:0]            m_q;
  logic [1:0]            sel_q;
  logic                  capture;
  logic                  cnt_clr;
  logic                  cnt_adv;
  logic                  cnt_last;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic [1:0]            row_bound;
  logic [1:0]            col_bound;
  logic [BIT_IDX_W-1:0]  word_lsb;
  logic [BUS_WIDTH-1:0]  word_sel;
  logic [BUS_WIDTH-1:0]  word_out;

  // Padding mode sweeps the full slot; otherwise only the n x m region.
  always_comb begin
`ifdef SP_WR_CLEAR_PAD_EN
    row_bound = 2'(MAX_DIM - 1);
    col_bound = 2'(MAX_DIM - 1);
`else
    row_bound = n_q;
    col_bound = m_q;
`endif
  end

  sp_wr_addr_gen u_addr_gen (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clr_i       (cnt_clr),
    .adv_i       (cnt_adv),
    .row_bound_i (row_bound),
    .col_bound_i (col_bound),
    .last_o      (cnt_last),
    .addr_o      (cnt_addr)
  );

  // Pick the captured word at the current address; zero it outside the region when padding.
  always_comb begin
    word_lsb = BIT_IDX_W'(cnt_addr) * BIT_IDX_W'(BUS_WIDTH);
    word_sel = mat_q[word_lsb +: BUS_WIDTH];
`ifdef SP_WR_CLEAR_PAD_EN
    if ((cnt_addr[ADDR_WIDTH-1:2] <= n_q) && (cnt_addr[1:0] <= m_q)) begin
      word_out = word_sel;
    end else begin
      word_out = '0;
    end
`else
    word_out = word_sel;
`endif
  end

  // Snapshot the job on the accepting edge so the producer may change its inputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mat_q <= '0;
      n_q   <= 2'd0;
      m_q   <= 2'd0;
      sel_q <= 2'd0;
    end else if (capture) begin
      mat_q <= mat_flat_i;
      n_q   <= n_dim_i;
      m_q   <= m_dim_i;
      sel_q <= target_sel_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and port outputs; the port is driven only while writing.
  always_comb begin
    state_d             = state_q;
    capture             = 1'b0;
    cnt_clr             = 1'b0;
    cnt_adv             = 1'b0;
    ien_o               = 1'b0;
    addr_o              = '0;
    din_o               = '0;
    element_write_sel_o = 2'd0;
    busy_o              = (state_q != IDLE);
    done_o              = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          capture = 1'b1;
          cnt_clr = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ien_o               = !hold_i;
        cnt_adv             = !hold_i;
        addr_o              = cnt_addr;
        din_o               = word_out;
        element_write_sel_o = sel_q;
        if (!hold_i && cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
